// File: rtl/key_debounce_encoder_if.sv
// Button/key bundle between the raw push-button pins and the tone generator.
// master drives the raw buttons; slave is the debouncer/encoder.
interface key_debounce_encoder_if #(
    parameter int NUM_KEYS = 8,
    parameter int IDX_W    = 3
);
    logic [NUM_KEYS-1:0] btn;
    logic [NUM_KEYS-1:0] key_mask;
    logic [IDX_W-1:0]    key_idx;
    logic                key_valid;
    logic                key_press;
    logic                key_release;

    modport master (
        output btn,
        input  key_mask,
        input  key_idx,
        input  key_valid,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  btn,
        output key_mask,
        output key_idx,
        output key_valid,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_debounce_encoder.sv
// Sync + debounce active-low buttons, priority-encode to a note index with press/release pulses.
// Optional macro KEY_HOLD_EN: key_idx keeps the last note after release instead of clearing.
module key_debounce_encoder #(
    parameter int NUM_KEYS        = 8,
    parameter int IDX_W           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    key_debounce_encoder_if.slave       bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((2 ** IDX_W) < NUM_KEYS) begin : g_bad_idx_w
        $error("IDX_W too small for NUM_KEYS");
    end
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] mask_q;
    logic [IDX_W-1:0]    winner;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                valid_q;
    logic                valid_d;
    logic                press_q;
    logic                press_d;
    logic                rel_q;
    logic                rel_d;

    // Sync flops hold the raw active-low level, so reset means "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
        logic [CNT_W-1:0] cnt_q;
        logic             m_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                m_q   <= 1'b0;
            end else if (pressed[i] == m_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                m_q   <= pressed[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign mask_q[i] = m_q;
    end

    // Later iterations overwrite earlier ones: highest held index wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (mask_q[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|mask_q) begin
                    state_d = PRESSED;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (~|mask_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    rel_d   = 1'b1;
`ifdef KEY_HOLD_EN
                    idx_d   = idx_q;
`else
                    idx_d   = '0;
`endif
                end else if (winner != idx_q) begin
                    idx_d   = winner;
                    press_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_mask    = mask_q;
    assign bus.key_idx     = idx_q;
    assign bus.key_valid   = valid_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = rel_q;

    a_pulse_excl: assert property (
        @(posedge clk) disable iff (rst) !(press_q && rel_q)
    );

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Scoreboard bench for key_debounce_encoder with DEBOUNCE_CYCLES=4, NUM_KEYS=8.
// Stimulus pushes expected pulses; a negedge monitor pops and compares them.
module tb_key_debounce_encoder;

    localparam int NK  = 8;
    localparam int IW  = 3;
    localparam int DB  = 4;
    localparam int CW  = 3;
    localparam int LAT = 3 + DB;

    typedef struct {
        bit rel;
        int idx;
        bit valid;
        int mask;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];
    int   last_idx = 0;

    key_debounce_encoder_if #(.NUM_KEYS(NK), .IDX_W(IW)) bus ();

    key_debounce_encoder #(
        .NUM_KEYS(NK),
        .IDX_W(IW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.key_press && bus.key_release) begin
                chk("press_and_release", 1, 0);
            end
            if (bus.key_press || bus.key_release) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("ev_kind", int'(bus.key_release), int'(e.rel));
                    chk("ev_idx", int'(bus.key_idx), e.idx);
                    chk("ev_valid", int'(bus.key_valid), int'(e.valid));
                    chk("ev_mask", int'(bus.key_mask), e.mask);
                    chk("ev_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic expect_ev(bit rel, int idx, bit valid, int mask);
        ev_t e;
        e.rel   = rel;
        e.idx   = idx;
        e.valid = valid;
        e.mask  = mask;
        e.cyc   = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic press(logic [NK-1:0] b, int idx, int mask);
        @(negedge clk);
        bus.btn = b;
        last_idx = idx;
        expect_ev(1'b0, idx, 1'b1, mask);
        drain();
    endtask

    task automatic release_all();
        @(negedge clk);
        bus.btn = '1;
`ifdef KEY_HOLD_EN
        expect_ev(1'b1, last_idx, 1'b0, 0);
`else
        expect_ev(1'b1, 0, 1'b0, 0);
`endif
        drain();
    endtask

    task automatic check_idle(string name);
        chk({name, "_mask"}, int'(bus.key_mask), 0);
        chk({name, "_valid"}, int'(bus.key_valid), 0);
        chk({name, "_press"}, int'(bus.key_press), 0);
        chk({name, "_release"}, int'(bus.key_release), 0);
    endtask

    initial begin
        bus.btn = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_idx", int'(bus.key_idx), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_idle("no_press");
        chk("no_press_idx", int'(bus.key_idx), 0);

        // reset part-way through a debounce count
        bus.btn = 8'hFB;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_ev(1'b0, 2, 1'b1, 8'h04);
        repeat (LAT - 1) @(negedge clk);
        chk("mask_edge6", int'(bus.key_mask), 8'h04);
        chk("valid_edge6", int'(bus.key_valid), 0);
        drain();
        last_idx = 2;
        release_all();

        // bounce 0/1/0 then stable low
        @(negedge clk);
        bus.btn = 8'hFB;
        @(negedge clk);
        bus.btn = 8'hFF;
        press(8'hFB, 2, 8'h04);

        // short glitch on key0 while key2 held
        @(negedge clk);
        bus.btn = 8'hFA;
        repeat (2) @(negedge clk);
        bus.btn = 8'hFB;
        repeat (15) @(negedge clk);
        chk("held_glitch_mask", int'(bus.key_mask), 8'h04);
        chk("held_glitch_idx", int'(bus.key_idx), 2);

        press(8'hDB, 5, 8'h24);
        press(8'hFB, 2, 8'h04);
        release_all();

        // simultaneous press of keys 1 and 6
        press(8'hBD, 6, 8'h42);
        release_all();

        // isolated 2-cycle glitch on key0
        @(negedge clk);
        bus.btn = 8'hFE;
        repeat (2) @(negedge clk);
        bus.btn = 8'hFF;
        repeat (15) @(negedge clk);
        check_idle("glitch");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
